// File: rtl/data_collect_ctrl_if.sv
// ============================================================================
// Module   : data_collect_ctrl_if
// Brief    : Capture/playback streams and memory control pins of the collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface data_collect_ctrl_if #(
    parameter int CW = 10
);
    logic          start_capture;
    logic          stop_capture;
    logic          start_play;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          busy;
    logic [31:0]   mem_address;
    logic          mem_out_en;
    logic          mem_active;
    logic          mem_RW;

    modport master (
        input  start_capture, stop_capture, start_play,
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, full, busy,
        output mem_address, mem_out_en, mem_active, mem_RW
    );

    modport slave (
        output start_capture, stop_capture, start_play,
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, full, busy,
        input  mem_address, mem_out_en, mem_active, mem_RW
    );
endinterface

`default_nettype wire

// File: rtl/data_collect_ctrl.sv
// ============================================================================
// Module   : data_collect_ctrl
// Brief    : Stream-to-memory capture and ordered playback bus initiator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_collect_ctrl #(
    parameter int DEPTH = 750,
    parameter int CW    = 10
) (
    input  wire logic            clk,
    input  wire logic            reset,
    data_collect_ctrl_if.master  bus,
    inout  wire logic [7:0]      mem_data
);

    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [CW-1:0] c_one   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAPTURE  = 3'd1,
        S_WRITE    = 3'd2,
        S_RD_REQ   = 3'd3,
        S_RD_CAP   = 3'd4,
        S_OUT_HOLD = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    wbyte_q, wbyte_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic [CW-1:0] addr_q, addr_d;
    logic          active_q, active_d;
    logic          rw_q, rw_d;
    logic          out_en_q, out_en_d;
    logic          drive_q, drive_d;
    logic [CW-1:0] ptr_inc;

    assign ptr_inc = ptr_q + c_one;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            wbyte_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            addr_q      <= '0;
            active_q    <= 1'b0;
            rw_q        <= 1'b1;
            out_en_q    <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            wbyte_q     <= wbyte_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            addr_q      <= addr_d;
            active_q    <= active_d;
            rw_q        <= rw_d;
            out_en_q    <= out_en_d;
            drive_q     <= drive_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        wbyte_d     = wbyte_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        addr_d      = addr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_capture) begin
                    count_d = '0;
                    ptr_d   = '0;
                    state_d = S_CAPTURE;
                end else if (bus.start_play && (count_q != '0)) begin
                    ptr_d   = '0;
                    addr_d  = '0;
                    state_d = S_RD_REQ;
                end
            end
            S_CAPTURE: begin
                // Stop wins over a same-cycle handshake; that byte is dropped.
                if (bus.stop_capture || (count_q == c_depth)) begin
                    state_d = S_IDLE;
                end else if (bus.in_valid && in_ready_q) begin
                    wbyte_d = bus.in_data;
                    addr_d  = ptr_q;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ptr_d   = ptr_inc;
                count_d = count_q + c_one;
                state_d = S_CAPTURE;
            end
            S_RD_REQ: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                out_data_d  = mem_data;
                out_valid_d = 1'b1;
                state_d     = S_OUT_HOLD;
            end
            S_OUT_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    ptr_d       = ptr_inc;
                    if (ptr_inc == count_q) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = ptr_inc;
                        state_d = S_RD_REQ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus pins and in_ready are decoded from the next state so they leave the flops cleanly.
        in_ready_d = (state_d == S_CAPTURE) && (count_d != c_depth);
        active_d   = (state_d == S_WRITE) || (state_d == S_RD_REQ) || (state_d == S_RD_CAP);
        rw_d       = (state_d != S_WRITE);
        out_en_d   = !((state_d == S_RD_REQ) || (state_d == S_RD_CAP));
        drive_d    = (state_d == S_WRITE);
    end

    assign mem_data        = drive_q ? wbyte_q : 8'bz;

    assign bus.in_ready    = in_ready_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.count       = count_q;
    assign bus.full        = (count_q == c_depth);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.mem_address = {{(32-CW){1'b0}}, addr_q};
    assign bus.mem_out_en  = out_en_q;
    assign bus.mem_active  = active_q;
    assign bus.mem_RW      = rw_q;

endmodule

`default_nettype wire

// File: tb/tb_data_collect_ctrl.sv
// ============================================================================
// Module   : tb_data_collect_ctrl
// Brief    : Directed bench for data_collect_ctrl with a small memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_collect_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire  [7:0] mem_data;

    int n_checks = 0;
    int n_errors = 0;

    data_collect_ctrl_if #(.CW(CW)) bus ();

    data_collect_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (bus.master),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Memory model: stores on write condition, loads MDR and drives bus on read condition.
    logic [7:0] mem [0:7];
    logic [7:0] mdr;
    logic       rd_cond;
    assign rd_cond  = bus.mem_active && bus.mem_RW && !bus.mem_out_en;
    assign mem_data = rd_cond ? mdr : 8'bz;

    always @(posedge clk) begin
        if (bus.mem_active && !bus.mem_RW && bus.mem_out_en)
            mem[bus.mem_address[2:0]] <= mem_data;
        if (rd_cond)
            mdr <= mem[bus.mem_address[2:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_bus(input string tag);
        check_eq({tag, "_active"}, 32'(bus.mem_active), 32'd0);
        check_eq({tag, "_rw"},     32'(bus.mem_RW),     32'd1);
        check_eq({tag, "_out_en"}, 32'(bus.mem_out_en), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        check_eq({tag, "_count"},     32'(bus.count),     32'd0);
        check_eq({tag, "_full"},      32'(bus.full),      32'd0);
        check_eq({tag, "_busy"},      32'(bus.busy),      32'd0);
        check_eq({tag, "_addr"},      bus.mem_address,    32'd0);
        check_idle_bus(tag);
    endtask

    // Offer one byte in CAPTURE and follow it through its single WRITE cycle.
    task automatic send_byte(input logic [7:0] b, input int idx);
        int cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && cyc < 10) begin
            tick();
            cyc++;
        end
        check_eq("in_ready_wait", 32'(cyc < 10), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check_eq("wr_active", 32'(bus.mem_active), 32'd1);
        check_eq("wr_rw",     32'(bus.mem_RW),     32'd0);
        check_eq("wr_out_en", 32'(bus.mem_out_en), 32'd1);
        check_eq("wr_addr",   bus.mem_address,     32'(idx));
        check_eq("wr_data",   32'(mem_data),       32'(b));
        check_eq("wr_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check_eq("wr_count",  32'(bus.count),      32'(idx + 1));
        check_eq("wr_one_cycle", 32'(bus.mem_active), 32'd0);
    endtask

    // Count cycles (including a pending handshake edge) until out_valid, then check byte and spacing.
    task automatic recv(input logic [7:0] exp, input int exp_cyc);
        int cyc = 0;
        do begin
            tick();
            bus.start_play = 1'b0;
            cyc++;
        end while (!bus.out_valid && cyc < 20);
        check_eq("rd_latency", 32'(cyc), 32'(exp_cyc));
        check_eq("rd_data",    32'(bus.out_data), 32'(exp));
    endtask

    initial begin
        bus.start_capture = 1'b0;
        bus.stop_capture  = 1'b0;
        bus.start_play    = 1'b0;
        bus.in_data       = 8'h00;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b0;

        tick();
        tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Capture 3,5,2 then stop.
        bus.start_capture = 1'b1;
        tick();
        bus.start_capture = 1'b0;
        check_eq("cap_busy", 32'(bus.busy), 32'd1);
        send_byte(8'd3, 0);
        send_byte(8'd5, 1);
        send_byte(8'd2, 2);
        bus.stop_capture = 1'b1;
        tick();
        bus.stop_capture = 1'b0;
        check_eq("cap_count", 32'(bus.count), 32'd3);
        check_eq("cap_busy_drop", 32'(bus.busy), 32'd0);
        check_eq("cap_in_ready", 32'(bus.in_ready), 32'd0);
        check_idle_bus("cap_idle");

        // Playback with the sink always ready.
        bus.out_ready  = 1'b1;
        bus.start_play = 1'b1;
        recv(8'd3, 3);
        recv(8'd5, 3);
        recv(8'd2, 3);
        tick();
        check_eq("play_valid_clear", 32'(bus.out_valid), 32'd0);
        check_eq("play_done_busy", 32'(bus.busy), 32'd0);

        // Playback with backpressure on the second byte.
        bus.start_play = 1'b1;
        recv(8'd3, 3);
        recv(8'd5, 3);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
            check_eq("bp_data",  32'(bus.out_data),  32'd5);
            check_eq("bp_active", 32'(bus.mem_active), 32'd0);
            check_eq("bp_addr",  bus.mem_address,    32'd1);
        end
        bus.out_ready = 1'b1;
        recv(8'd2, 3);
        tick();
        check_eq("bp_done_busy", 32'(bus.busy), 32'd0);

        // Full boundary: six bytes offered back to back, only DEPTH accepted.
        begin
            int hs = 0;
            int k  = 0;
            bus.start_capture = 1'b1;
            tick();
            bus.start_capture = 1'b0;
            for (int t = 0; t < 14; t++) begin
                logic rdy;
                bus.in_valid = (k < 6);
                bus.in_data  = 8'(8'd10 + k);
                rdy = bus.in_ready;
                tick();
                if (rdy && k < 6) begin
                    hs++;
                    k++;
                end
            end
            bus.in_valid = 1'b0;
            check_eq("full_handshakes", 32'(hs), 32'd4);
            check_eq("full_count", 32'(bus.count), 32'd4);
            check_eq("full_flag", 32'(bus.full), 32'd1);
            check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("full_busy", 32'(bus.busy), 32'd0);
            check_eq("full_mem0", 32'(mem[0]), 32'd10);
            check_eq("full_mem3", 32'(mem[3]), 32'd13);
        end

        // Both starts together: capture wins and clears count.
        bus.start_capture = 1'b1;
        bus.start_play    = 1'b1;
        tick();
        bus.start_capture = 1'b0;
        bus.start_play    = 1'b0;
        check_eq("both_busy", 32'(bus.busy), 32'd1);
        check_eq("both_count", 32'(bus.count), 32'd0);
        check_eq("both_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("both_active", 32'(bus.mem_active), 32'd0);
        bus.stop_capture = 1'b1;
        tick();
        bus.stop_capture = 1'b0;
        check_eq("empty_stop_busy", 32'(bus.busy), 32'd0);
        bus.start_play = 1'b1;
        tick();
        bus.start_play = 1'b0;
        check_eq("empty_play_busy", 32'(bus.busy), 32'd0);
        check_eq("empty_play_active", 32'(bus.mem_active), 32'd0);

        // Reset asserted while in RD_CAP.
        bus.start_capture = 1'b1;
        tick();
        bus.start_capture = 1'b0;
        send_byte(8'd7, 0);
        bus.stop_capture = 1'b1;
        tick();
        bus.stop_capture = 1'b0;
        bus.start_play = 1'b1;
        tick();
        bus.start_play = 1'b0;
        tick();
        check_eq("rdcap_active", 32'(bus.mem_active), 32'd1);
        check_eq("rdcap_out_en", 32'(bus.mem_out_en), 32'd0);
        rst_n = 1'b0;
        tick();
        check_reset_vals("midreset");
        rst_n = 1'b1;
        tick();
        bus.start_play = 1'b1;
        tick();
        bus.start_play = 1'b0;
        check_eq("post_reset_play_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
